wallace_mult4: RTL and testbench

- 4x4 unsigned multiplier built as a hand-structured Wallace tree (AND-array partial products, 3:2/2:2 counter reduction, final carry-propagate adder).
- Primary product output is purely combinational.
- A one-cycle registered copy with a valid flag is provided for pipelined consumers in the same clock domain.
- Leaf arithmetic block; no handshake back-pressure.

---
 rtl/wallace_mult4.sv | 173 +++++++++++++++++
 tb/tb_wallace_mult4.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/wallace_mult4.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : wallace_mult4 (with helper cells wallace_mult4_ha, wallace_mult4_fa)
// Purpose  : 4x4 unsigned multiplier built as a hand-structured Wallace tree.
//            The design forms an AND-array of partial products. Two layers of
//            3:2 / 2:2 counters reduce every column to two bits. A ripple-carry
//            adder then produces the 8-bit product.
//            The product is available combinationally on prod. A registered
//            copy (prod_q) with a valid flag (out_valid) is also provided.
// Ports    : clk       in   1  system clock, rising edge
//            rst       in   1  synchronous active-high reset
//            a         in   4  unsigned multiplicand
//            b         in   4  unsigned multiplier
//            in_valid  in   1  qualifies a/b for the registered path
//            prod      out  8  combinational product a*b
//            prod_q    out  8  registered product, one cycle after capture
//            out_valid out  1  registered in_valid, qualifies prod_q
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------

//------------------------------------------------------------------------------
// Half adder (2:2 counter)
//------------------------------------------------------------------------------
module wallace_mult4_ha (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

//------------------------------------------------------------------------------
// Full adder (3:2 counter)
//------------------------------------------------------------------------------
module wallace_mult4_fa (
  input  logic i_x,
  input  logic i_y,
  input  logic i_z,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y ^ i_z;
  assign o_c = (i_x & i_y) | (i_x & i_z) | (i_y & i_z);
endmodule

//------------------------------------------------------------------------------
// Top: Wallace-tree multiplier
//------------------------------------------------------------------------------
module wallace_mult4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       in_valid,
  output logic [7:0] prod,
  output logic [7:0] prod_q,
  output logic       out_valid
);

  // w_pp[i][j] = a[j] & b[i], weight 2^(i+j)
  logic [3:0][3:0] w_pp;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pp_row
    for (genvar gj = 0; gj < 4; gj++) begin : g_pp_col
      assign w_pp[gi][gj] = a[gj] & b[gi];
    end
  end

  // Stage 1. Naming: w_st1_sK is a sum kept in column K. w_st1_cK is the
  // carry out of column K, which moves into column K+1.
  // Heights in : 1 2 3 4 3 2 1  (columns 0..6)
  // Heights out: 1 1 2 3 2 2 2  (column 3 keeps pp[3][0] as its third bit)
  logic w_st1_s1, w_st1_c1;
  logic w_st1_s2, w_st1_c2;
  logic w_st1_s3, w_st1_c3;
  logic w_st1_s4, w_st1_c4;
  logic w_st1_s5, w_st1_c5;

  wallace_mult4_ha u_st1_col1 (
    .i_x(w_pp[0][1]), .i_y(w_pp[1][0]),
    .o_s(w_st1_s1),   .o_c(w_st1_c1)
  );
  wallace_mult4_fa u_st1_col2 (
    .i_x(w_pp[0][2]), .i_y(w_pp[1][1]), .i_z(w_pp[2][0]),
    .o_s(w_st1_s2),   .o_c(w_st1_c2)
  );
  wallace_mult4_fa u_st1_col3 (
    .i_x(w_pp[0][3]), .i_y(w_pp[1][2]), .i_z(w_pp[2][1]),
    .o_s(w_st1_s3),   .o_c(w_st1_c3)
  );
  wallace_mult4_fa u_st1_col4 (
    .i_x(w_pp[1][3]), .i_y(w_pp[2][2]), .i_z(w_pp[3][1]),
    .o_s(w_st1_s4),   .o_c(w_st1_c4)
  );
  wallace_mult4_ha u_st1_col5 (
    .i_x(w_pp[2][3]), .i_y(w_pp[3][2]),
    .o_s(w_st1_s5),   .o_c(w_st1_c5)
  );

  // Stage 2 brings column 3 down from 3 bits to 1. Columns 4..6 are each
  // half-added so that the incoming carries do not push any column back
  // above two bits.
  // Heights out: 1 1 2 1 2 2 2 1  (columns 0..7)
  logic w_st2_s3, w_st2_c3;
  logic w_st2_s4, w_st2_c4;
  logic w_st2_s5, w_st2_c5;
  logic w_st2_s6, w_st2_c6;

  wallace_mult4_fa u_st2_col3 (
    .i_x(w_st1_s3), .i_y(w_pp[3][0]), .i_z(w_st1_c2),
    .o_s(w_st2_s3), .o_c(w_st2_c3)
  );
  wallace_mult4_ha u_st2_col4 (
    .i_x(w_st1_s4), .i_y(w_st1_c3),
    .o_s(w_st2_s4), .o_c(w_st2_c4)
  );
  wallace_mult4_ha u_st2_col5 (
    .i_x(w_st1_s5), .i_y(w_st1_c4),
    .o_s(w_st2_s5), .o_c(w_st2_c5)
  );
  wallace_mult4_ha u_st2_col6 (
    .i_x(w_pp[3][3]), .i_y(w_st1_c5),
    .o_s(w_st2_s6),   .o_c(w_st2_c6)
  );

  // Two rows for the carry-propagate adder. Empty positions are tied to 0.
  logic [7:0] w_row0;
  logic [7:0] w_row1;

  assign w_row0 = {w_st2_c6, w_st2_s6, w_st2_s5, w_st2_s4,
                   w_st2_s3, w_st1_s2, w_st1_s1, w_pp[0][0]};
  assign w_row1 = {1'b0, w_st2_c5, w_st2_c4, w_st2_c3,
                   1'b0, w_st1_c1, 1'b0, 1'b0};

  // Ripple-carry adder for bits 0..6. Bit 7 needs only its sum, because the
  // product never exceeds 225 and so the carry out of bit 7 is always zero.
  logic [7:0] w_cy;
  logic [6:0] w_sum;

  assign w_cy[0] = 1'b0;

  for (genvar gk = 0; gk < 7; gk++) begin : g_cpa
    wallace_mult4_fa u_cpa_fa (
      .i_x(w_row0[gk]), .i_y(w_row1[gk]), .i_z(w_cy[gk]),
      .o_s(w_sum[gk]),  .o_c(w_cy[gk+1])
    );
  end

  assign prod = {w_row0[7] ^ w_row1[7] ^ w_cy[7], w_sum};

  // Registered copy for same-domain pipelined consumers
  logic [7:0] r_prod_q;
  logic       r_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod_q    <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_prod_q <= prod;
      end
    end
  end

  assign prod_q    = r_prod_q;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_wallace_mult4.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_wallace_mult4
// Purpose  : Self-checking bench for wallace_mult4.
//            It covers the combinational product, corner operands, reset,
//            pipeline, hold, simultaneous reset/valid and random streaming.
//            Registered results are tracked with a queue-based scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_wallace_mult4;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic [7:0] prod;
  logic [7:0] prod_q;
  logic       out_valid;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [7:0] sb_q [$];
  logic [7:0] hold_val;

  wallace_mult4 u_dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .prod     (prod),
    .prod_q   (prod_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
    int unsigned p;
    p = int'(x) * int'(y);
    return p[7:0];
  endfunction

  // Advance one clock. The expected product is pushed before the edge when a
  // capture should happen. After the edge the registered outputs are checked.
  task automatic step();
    logic       exp_v;
    logic [7:0] exp_p;
    exp_v = in_valid && !rst;
    if (exp_v) sb_q.push_back(ref_mul(a, b));
    @(posedge clk);
    #1;
    check("out_valid", {7'b0, out_valid}, {7'b0, exp_v});
    if (out_valid === 1'b1 && sb_q.size() > 0) begin
      exp_p = sb_q.pop_front();
      check("prod_q", prod_q, exp_p);
      hold_val = exp_p;
    end else begin
      if (sb_q.size() > 0) begin
        hold_val = sb_q.pop_front();
      end else if (rst) begin
        hold_val = 8'h00;
      end
      check("prod_q_hold", prod_q, hold_val);
    end
  endtask

  task automatic comb_check(input string tag, input logic [3:0] x, input logic [3:0] y);
    a = x;
    b = y;
    #1;
    check(tag, prod, ref_mul(x, y));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    hold_val = 8'h00;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 4'd7;
    b        = 4'd9;

    // Reset held for two edges with in_valid high: the product is still live
    #1;
    check("rst_prod", prod, 8'd63);
    step();
    check("rst_prod", prod, 8'd63);
    step();

    // Back-to-back pipeline
    rst = 1'b0;
    a = 4'd3;  b = 4'd5;  step();
    a = 4'd15; b = 4'd15; step();
    a = 4'd0;  b = 4'd9;  step();
    in_valid = 1'b0;      step();

    // Hold: capture 6*7, then drop in_valid while the operands change
    in_valid = 1'b1; a = 4'd6; b = 4'd7; step();
    in_valid = 1'b0; a = 4'd2; b = 4'd2;
    #1;
    check("hold_comb", prod, 8'd4);
    step();
    step();
    check("hold_val", prod_q, 8'd42);

    // Reset and valid on the same edge: reset wins
    rst = 1'b1; in_valid = 1'b1; a = 4'd15; b = 4'd15; step();
    rst = 1'b0; step();
    check("sim_capture", prod_q, 8'hE1);
    in_valid = 1'b0; step();

    // Corner operands
    comb_check("c_0x15",  4'd0,  4'd15);
    comb_check("c_15x15", 4'd15, 4'd15);
    check("c_15x15_lit", prod, 8'hE1);
    comb_check("c_1x13",  4'd1,  4'd13);
    comb_check("c_8x8",   4'd8,  4'd8);
    check("c_8x8_lit", prod, 8'd64);
    comb_check("c_15x1",  4'd15, 4'd1);

    // Exhaustive combinational sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        comb_check("sweep", 4'(i), 4'(j));
      end
    end

    // Random streaming with sporadic valid and a mid-stream reset
    for (int k = 0; k < 60; k++) begin
      a        = 4'($urandom_range(0, 15));
      b        = 4'($urandom_range(0, 15));
      in_valid = ($urandom_range(0, 3) != 0);
      rst      = (k == 30);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
